mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 95 +++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory model with bench-controlled wait states, halfword check ports and protocol monitor.
module mem_responder #(
  parameter int    DEPTH     = 256,
  parameter int    MAX_WAIT  = 4,
  parameter int    NCHECK    = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  input  logic                 stall_req,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  input  logic [NCHECK*32-1:0] chk_addr,
  output logic [NCHECK*16-1:0] chk_data,
  output logic [31:0]          fetch_cnt,
  output logic                 protocol_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state;
  logic [4:0]    r_wait_cnt;
  logic [31:0]   r_addr, r_wdata, r_fetch_cnt;
  logic [3:0]    r_wstrb;
  logic          r_instr, r_ready, r_err;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic          w_changed, w_unused;
  assign w_idx        = r_addr[AW+1:2];
  assign w_changed    = {mem_addr, mem_wdata, mem_wstrb} != {r_addr, r_wdata, r_wstrb};
  assign mem_ready    = r_ready;
  assign mem_rdata    = (r_state == RESP && r_wstrb == 4'd0) ? r_mem[w_idx] : 32'd0;
  assign fetch_cnt    = r_fetch_cnt;
  assign protocol_err = r_err;
  assign w_unused     = &{1'b0, chk_addr};
  always_ff @(posedge clk)
    if (reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_ready     <= 1'b0;
      r_fetch_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (mem_valid) begin
          r_addr     <= mem_addr;
          r_wdata    <= mem_wdata;
          r_wstrb    <= mem_wstrb;
          r_instr    <= mem_instr;
          r_wait_cnt <= '0;
          r_state    <= stall_req ? WAIT : RESP;
          r_ready    <= !stall_req;
          r_err      <= r_err | (mem_addr[1:0] != 2'd0);
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 5'd1;
          if (!mem_valid) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_err <= r_err | w_changed;
            if (!stall_req || r_wait_cnt == 5'(MAX_WAIT - 1)) begin
              r_state <= RESP;
              r_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_ready     <= 1'b0;
          r_wait_cnt  <= '0;
          r_err       <= r_err | !mem_valid;
          r_fetch_cnt <= r_fetch_cnt + {31'd0, r_instr};
        end
      endcase
    end
`ifdef MEM_RESPONDER_WRITE_EN
  always_ff @(posedge clk)
    if (!reset && r_state == RESP)
      for (int b = 0; b < 4; b++)
        if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
`else
  logic w_unused_wr;
  assign w_unused_wr = &{1'b0, r_wdata};
`endif
  for (genvar i = 0; i < NCHECK; i++) begin : g_chk
    logic [31:0] w_word;
    assign w_word = r_mem[chk_addr[32*i+2 +: AW]];
    assign chk_data[16*i +: 16] = chk_addr[32*i+1] ? w_word[31:16] : w_word[15:0];
  end
endmodule
